// File: rtl/td4_datapath.sv
// TD4 register/ALU datapath: source mux, WIDTH-bit adder with carry out,
// A/B/OUT registers, program counter and carry flag.
module td4_datapath #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic [1:0]       sel,
  input  logic [3:0]       load,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] pc,
  output logic             carry_flag,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b
);

  // Index 0 = A, 1 = B, 2 = OUT, matching load[2:0].
  logic [WIDTH-1:0] gpr_reg [3];
  logic [WIDTH-1:0] pc_reg;
  logic             carry_reg;

  logic [WIDTH-1:0] src;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_next;
  logic             carry_next;
  logic [WIDTH-1:0] pc_next;

  always_comb begin
    src = '0;
    case (sel)
      2'b00:   src = gpr_reg[0];
      2'b01:   src = gpr_reg[1];
      2'b10:   src = in_port;
      default: src = '0;
    endcase
  end

  assign sum        = {1'b0, src} + {1'b0, imm};
  assign res_next   = sum[WIDTH-1:0];
  assign carry_next = sum[WIDTH];
  assign pc_next    = load[3] ? pc_reg + 1'b1 : res_next;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_gpr
      always_ff @(posedge clk) begin
        if (!rst_n)
          gpr_reg[gi] <= '0;
        else if (step_en && !load[gi])
          gpr_reg[gi] <= res_next;
      end
    end
  endgenerate

  // Carry updates on every executed instruction, including jumps and no-writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg    <= PC_RESET;
      carry_reg <= 1'b0;
    end else if (step_en) begin
      pc_reg    <= pc_next;
      carry_reg <= carry_next;
    end
  end

  assign reg_a      = gpr_reg[0];
  assign reg_b      = gpr_reg[1];
  assign out_port   = gpr_reg[2];
  assign pc         = pc_reg;
  assign carry_flag = carry_reg;

endmodule
